// File: rtl/srgen_debounce_pkg.sv
// -----------------------------------------------------------------------------
// srgen_debounce_pkg
// Shared constants and helpers for the SR-flip-flop input conditioner.
//   clog2()         : ceiling log2, used to size the debounce/repeat counters
//   DB_CYCLES_DEF   : default debounce length in clock edges
//   REP_CYCLES_DEF  : default auto-repeat period in clock cycles
// -----------------------------------------------------------------------------
package srgen_debounce_pkg;

    localparam int DB_CYCLES_DEF  = 4;
    localparam int REP_CYCLES_DEF = 8;

    // Smallest w with 2**w >= v (returns 0 for v <= 1).
    function automatic int clog2(input int v);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/srgen_debounce_debounce1.sv
// -----------------------------------------------------------------------------
// debounce1
// One push-button channel: two-flop synchroniser, counting debouncer and a
// registered rising-edge detector on the debounced level.
// Parameters:
//   DB_CYCLES : consecutive edges the synchronised input must disagree with the
//               debounced level before the new level is accepted (>= 1)
// Ports:
//   ck    in  clock, rising edge active
//   rst_n in  synchronous active-low reset
//   raw   in  raw button line, asynchronous to ck
//   lvl   out debounced level
//   rise  out one-cycle pulse following a 0->1 change of lvl
// -----------------------------------------------------------------------------
module debounce1
    import srgen_debounce_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic ck,
    input  logic rst_n,
    input  logic raw,
    output logic lvl,
    output logic rise
);

    localparam int CW = clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          db;
    logic          db_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db    <= 1'b0;
            db_d  <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any agreement with the accepted level restarts the count, so a
            // bounce shorter than DB_CYCLES can never flip db.
            if (sync2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            db_d <= db;
            rise <= db & ~db_d;
        end
    end

    assign lvl = db;

endmodule

// File: rtl/srgen_debounce.sv
// -----------------------------------------------------------------------------
// srgen_debounce
// Input conditioner in front of a clocked SR flip-flop. Debounces a set key and
// a reset key and turns each debounced press into a single-cycle s / r pulse.
// s and r are never high together: when both pulses fall due in the same cycle
// both are dropped and conflict is raised for that cycle instead.
// Optional feature (macro SRGEN_AUTOREPEAT_EN): while a key stays held, a
// further pulse is emitted every REP_CYCLES cycles after the previous one.
// Parameters:
//   DB_CYCLES  : debounce length in clock edges (>= 1)
//   REP_CYCLES : auto-repeat period, only used with SRGEN_AUTOREPEAT_EN (>= 2)
// Ports:
//   ck       in  clock, rising edge active
//   rst_n    in  synchronous active-low reset
//   bs, br   in  raw set / reset buttons (asynchronous, bouncing)
//   s, r     out set / reset pulses to the flip-flop
//   sh, rh   out debounced levels of bs / br
//   conflict out both pulses were due this cycle and both were suppressed
// -----------------------------------------------------------------------------
module srgen_debounce
    import srgen_debounce_pkg::*;
#(
    parameter int DB_CYCLES  = DB_CYCLES_DEF,
    parameter int REP_CYCLES = REP_CYCLES_DEF
) (
    input  logic ck,
    input  logic rst_n,
    input  logic bs,
    input  logic br,
    output logic s,
    output logic r,
    output logic sh,
    output logic rh,
    output logic conflict
);

    if (DB_CYCLES < 1 || REP_CYCLES < 2) begin : g_bad_param
        $error("srgen_debounce: DB_CYCLES must be >= 1 and REP_CYCLES >= 2");
    end

    logic rise_s;
    logic rise_r;
    logic pulse_s;
    logic pulse_r;

    debounce1 #(.DB_CYCLES(DB_CYCLES)) u_set (
        .ck    (ck),
        .rst_n (rst_n),
        .raw   (bs),
        .lvl   (sh),
        .rise  (rise_s)
    );

    debounce1 #(.DB_CYCLES(DB_CYCLES)) u_rst (
        .ck    (ck),
        .rst_n (rst_n),
        .raw   (br),
        .lvl   (rh),
        .rise  (rise_r)
    );

`ifdef SRGEN_AUTOREPEAT_EN
    localparam int RW = clog2(REP_CYCLES);
    // The counter restarts on the edge that retires a pulse, so firing at
    // REP_CYCLES-2 puts the next pulse exactly REP_CYCLES cycles later.
    localparam logic [RW-1:0] REP_LAST = RW'(REP_CYCLES - 2);

    logic [RW-1:0] rep_cnt_s;
    logic [RW-1:0] rep_cnt_r;
    logic          rep_s;
    logic          rep_r;

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            rep_cnt_s <= '0;
            rep_cnt_r <= '0;
            rep_s     <= 1'b0;
            rep_r     <= 1'b0;
        end else begin
            if (!sh || pulse_s) begin
                rep_cnt_s <= '0;
                rep_s     <= 1'b0;
            end else if (rep_cnt_s == REP_LAST) begin
                rep_cnt_s <= '0;
                rep_s     <= 1'b1;
            end else begin
                rep_cnt_s <= rep_cnt_s + RW'(1);
                rep_s     <= 1'b0;
            end

            if (!rh || pulse_r) begin
                rep_cnt_r <= '0;
                rep_r     <= 1'b0;
            end else if (rep_cnt_r == REP_LAST) begin
                rep_cnt_r <= '0;
                rep_r     <= 1'b1;
            end else begin
                rep_cnt_r <= rep_cnt_r + RW'(1);
                rep_r     <= 1'b0;
            end
        end
    end

    assign pulse_s = rise_s | rep_s;
    assign pulse_r = rise_r | rep_r;
`else
    assign pulse_s = rise_s;
    assign pulse_r = rise_r;
`endif

    // Pulses are registered and reset-cleared, so these stay glitch-free.
    assign s        = pulse_s & ~pulse_r;
    assign r        = pulse_r & ~pulse_s;
    assign conflict = pulse_s & pulse_r;

endmodule

// File: tb/tb_srgen_debounce.sv
// -----------------------------------------------------------------------------
// tb_srgen_debounce
// Self-checking bench for srgen_debounce. The reference model keeps the raw
// sample history of each key and accepts a new level once the last DB_CYCLES
// synchronised samples all disagree with the current level; pulses follow one
// cycle after acceptance (plus periodic repeats when SRGEN_AUTOREPEAT_EN is
// defined). A falling-edge SR flip-flop sits on s/r as the downstream load.
// -----------------------------------------------------------------------------
module tb_srgen_debounce;

    localparam int DB  = 4;
    localparam int REP = 8;
`ifdef SRGEN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic ck = 1'b0;
    logic rst_n = 1'b0;
    logic bs = 1'b0;
    logic br = 1'b0;
    logic s, r, sh, rh, conflict;

    always #5 ck = ~ck;

    srgen_debounce #(.DB_CYCLES(DB), .REP_CYCLES(REP)) dut (
        .ck       (ck),
        .rst_n    (rst_n),
        .bs       (bs),
        .br       (br),
        .s        (s),
        .r        (r),
        .sh       (sh),
        .rh       (rh),
        .conflict (conflict)
    );

    // Downstream falling-edge SR flip-flop.
    logic q = 1'b0;
    always @(negedge ck) begin
        if (s && r)  q <= 1'bx;
        else if (s)  q <= 1'b1;
        else if (r)  q <= 1'b0;
    end

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // Reference model state per channel (0 = set key, 1 = reset key).
    bit hist [2][0:DB];   // hist[ch][k] = raw sampled k+1 edges ago
    bit m_db [2];
    bit m_rose [2];
    bit m_pulse [2];
    int m_last [2];

    // Per-window statistics, indices count edges since clr_stats.
    int idx, n_s, n_r, n_c, first_s, first_sh, first_c;
    int r_idx[$];

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst_v, input logic raw0, input logic raw1);
        bit raw, all_diff;
        edge_n++;
        for (int ch = 0; ch < 2; ch++) begin
            raw = (ch == 0) ? raw0 : raw1;
            if (!rst_v) begin
                for (int k = 0; k <= DB; k++) hist[ch][k] = 1'b0;
                m_db[ch]    = 1'b0;
                m_rose[ch]  = 1'b0;
                m_pulse[ch] = 1'b0;
                m_last[ch]  = -100000;
            end else begin
                m_pulse[ch] = m_rose[ch] ||
                              (AUTO && m_db[ch] && (edge_n - m_last[ch]) == REP);
                if (m_pulse[ch]) m_last[ch] = edge_n;
                // Synchronised samples seen at this edge are raw from 2..DB+1
                // edges ago; all must disagree with the accepted level.
                all_diff = 1'b1;
                for (int k = 1; k <= DB; k++) begin
                    if (hist[ch][k] == m_db[ch]) all_diff = 1'b0;
                end
                m_rose[ch] = !m_db[ch] && all_diff;
                if (all_diff) m_db[ch] = !m_db[ch];
                for (int k = DB; k >= 1; k--) hist[ch][k] = hist[ch][k-1];
                hist[ch][0] = raw;
            end
        end
    endtask

    task automatic clr_stats();
        idx = 0; n_s = 0; n_r = 0; n_c = 0;
        first_s = -1; first_sh = -1; first_c = -1;
        r_idx.delete();
    endtask

    task automatic cyc(input logic rst_v, input logic b0, input logic b1);
        @(negedge ck);
        rst_n = rst_v;
        bs    = b0;
        br    = b1;
        @(posedge ck);
        model_edge(rst_v, b0, b1);
        #1;
        chk("s",        s,        m_pulse[0] & ~m_pulse[1]);
        chk("r",        r,        m_pulse[1] & ~m_pulse[0]);
        chk("conflict", conflict, m_pulse[0] & m_pulse[1]);
        chk("sh",       sh,       m_db[0]);
        chk("rh",       rh,       m_db[1]);
        chk("s_and_r",  s & r,    1'b0);
        chk("q_known",  $isunknown(q), 1'b0);
        idx++;
        if (s) begin n_s++; if (first_s < 0) first_s = idx; end
        if (r) begin n_r++; r_idx.push_back(idx); end
        if (conflict) begin n_c++; if (first_c < 0) first_c = idx; end
        if (sh && first_sh < 0) first_sh = idx;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0] bounce;
        logic rb0, rb1, rrst;

        // 1. Reset with both keys held, then release with bs held.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1);
        chk("rst_s", s, 1'b0);
        chk("rst_sh", sh, 1'b0);
        clr_stats();
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b0);
        chk_int("rel_first_s", first_s, 7);
        chk_int("rel_n_s", n_s, 1);
        idle(14);

        // 2. Clean press held for 20 cycles.
        clr_stats();
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, 1'b0);
        chk_int("press_first_sh", first_sh, 6);
        chk_int("press_first_s", first_s, 7);
        chk_int("press_n_s", n_s, AUTO ? 2 : 1);
        idle(14);

        // 3. Bounce 1,0,1,1,0,1 then stable; last transition is edge 6.
        clr_stats();
        bounce = 6'b101101;
        for (int i = 5; i >= 0; i--) cyc(1'b1, bounce[i], 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0);
        chk_int("bounce_first_s", first_s, 12);
        chk_int("bounce_n_s", n_s, 1);
        idle(14);

        // 4. Simultaneous press.
        clr_stats();
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b1, 1'b1);
        chk_int("simul_n_s", n_s, 0);
        chk_int("simul_n_r", n_r, 0);
        chk_int("simul_first_c", first_c, 7);
        chk_int("simul_n_c", n_c, 1);
        chk("simul_sh", sh, 1'b1);
        chk("simul_rh", rh, 1'b1);
        idle(14);

`ifdef SRGEN_AUTOREPEAT_EN
        // 6. Auto-repeat on br held for 40 cycles, then released.
        clr_stats();
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0);
        chk_int("rep_n_r", r_idx.size(), 5);
        for (int k = 0; k < r_idx.size() && k < 5; k++) begin
            chk_int("rep_at", r_idx[k], 7 + 8 * k);
        end
`endif

        // 5. Random bounce on both keys with occasional reset.
        rb0 = 1'b0;
        rb1 = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) rb0 = ~rb0;
            if ($urandom_range(0, 7) == 0) rb1 = ~rb1;
            rrst = ($urandom_range(0, 399) != 0);
            cyc(rrst, rb0, rb1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
